// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and operand forwarding.
// Produces ALU operands and store data for the EX stage.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [5:0]  id_alucon,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dest,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_alusrc,
  input  logic        id_signext,
  input  logic        id_uses_rt,
  input  logic [3:0]  id_ctrl,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_result,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [5:0]  ex_alucon,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic [3:0]  ex_ctrl,
  output logic        load_use
);

  typedef struct packed {
    logic        valid;
    logic [5:0]  alucon;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        alusrc;
    logic        signext;
    logic [3:0]  ctrl;
  } id_ex_t;

  id_ex_t ex_q, ex_d, id_w;

  logic        ex_load, hit_rs, hit_rt;
  logic [31:0] frs, frt, ext;
  logic        shf_fix, shf_var;

  // ctrl = {regwrite, memread, memwrite, memtoreg}
  assign ex_load  = ex_q.valid & ex_q.ctrl[2] & (ex_q.dest != 5'd0);
  assign hit_rs   = (ex_q.dest == id_rs);
  assign hit_rt   = id_uses_rt & (ex_q.dest == id_rt);
  assign load_use = ex_load & id_valid & (hit_rs | hit_rt)
                    & ~stall & ~flush;

  always_comb begin
    id_w.valid   = id_valid;
    id_w.alucon  = id_alucon;
    id_w.rs      = id_rs;
    id_w.rt      = id_rt;
    id_w.dest    = id_dest;
    id_w.rs_data = id_rs_data;
    id_w.rt_data = id_rt_data;
    id_w.imm     = id_imm;
    id_w.shamt   = id_shamt;
    id_w.alusrc  = id_alusrc;
    id_w.signext = id_signext;
    id_w.ctrl    = id_ctrl;
  end

  always_comb begin
    ex_d = ex_q;
    priority case (1'b1)
      flush:    ex_d = '0;
      stall:    ex_d = ex_q;
      load_use: ex_d = '0;
      default:  ex_d = id_w;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // MEM is younger than WB, so it wins
  assign frs =
    (mem_regwrite && mem_dest == ex_q.rs && ex_q.rs != 5'd0) ? mem_result :
    (wb_regwrite  && wb_dest  == ex_q.rs && ex_q.rs != 5'd0) ? wb_result  :
    ex_q.rs_data;
  assign frt =
    (mem_regwrite && mem_dest == ex_q.rt && ex_q.rt != 5'd0) ? mem_result :
    (wb_regwrite  && wb_dest  == ex_q.rt && ex_q.rt != 5'd0) ? wb_result  :
    ex_q.rt_data;

  always_comb begin
    shf_fix = 1'b0;
    shf_var = 1'b0;
    case (ex_q.alucon)
      6'b000000, 6'b000010, 6'b000011: shf_fix = 1'b1;
      6'b000100, 6'b000110, 6'b000111: shf_var = 1'b1;
      default: ;
    endcase
  end

  assign ext = ex_q.signext ? {{16{ex_q.imm[15]}}, ex_q.imm}
                            : {16'b0, ex_q.imm};

  assign ex_a = (shf_fix | shf_var) ? frt : frs;
  assign ex_b = shf_fix     ? {27'b0, ex_q.shamt} :
                shf_var     ? frs :
                ex_q.alusrc ? ext : frt;

  assign ex_store_data = frt;
  assign ex_valid      = ex_q.valid;
  assign ex_alucon     = ex_q.alucon;
  assign ex_dest       = ex_q.dest;
  assign ex_ctrl       = ex_q.valid ? ex_q.ctrl : 4'b0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage.
// A behavioural EX-register model is compared against the DUT every cycle.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [5:0]  id_alucon;
  logic [4:0]  id_rs, id_rt, id_dest;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [4:0]  id_shamt;
  logic        id_alusrc, id_signext, id_uses_rt;
  logic [3:0]  id_ctrl;
  logic        stall, flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [5:0]  ex_alucon;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic [3:0]  ex_ctrl;
  logic        load_use;

  int n_chk = 0;
  int n_err = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_alucon(id_alucon),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_alusrc(id_alusrc), .id_signext(id_signext),
    .id_uses_rt(id_uses_rt), .id_ctrl(id_ctrl),
    .stall(stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_dest(mem_dest),
    .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
    .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_alucon(ex_alucon),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_ctrl(ex_ctrl), .load_use(load_use)
  );

  always #5 clk = ~clk;

  // Model of the instruction currently sitting in EX
  typedef struct packed {
    logic        v;
    logic [5:0]  op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rsd, rtd;
    logic [15:0] imm;
    logic [4:0]  sh;
    logic        src, sx;
    logic [3:0]  ctrl;
  } mdl_t;

  mdl_t m;

  function automatic logic m_lu();
    logic reads;
    reads = (m.dest == id_rs) || (id_uses_rt && m.dest == id_rt);
    return !stall && !flush && id_valid && m.v && m.ctrl[2]
           && m.dest != 5'd0 && reads;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r,
                                      input logic [31:0] d);
    if (r == 5'd0) return d;
    if (mem_regwrite && mem_dest == r) return mem_result;
    if (wb_regwrite && wb_dest == r) return wb_result;
    return d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else if (flush) m <= '0;
    else if (stall) m <= m;
    else if (m_lu()) m <= '0;
    else m <= '{v: id_valid, op: id_alucon, rs: id_rs, rt: id_rt,
                dest: id_dest, rsd: id_rs_data, rtd: id_rt_data,
                imm: id_imm, sh: id_shamt, src: id_alusrc,
                sx: id_signext, ctrl: id_ctrl};
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] rs_v, rt_v, ea, eb, immx;
    rs_v = fwd(m.rs, m.rsd);
    rt_v = fwd(m.rt, m.rtd);
    immx = m.sx ? 32'(signed'(m.imm)) : 32'(m.imm);
    if (m.op inside {6'd0, 6'd2, 6'd3}) begin
      ea = rt_v; eb = 32'(m.sh);
    end else if (m.op inside {6'd4, 6'd6, 6'd7}) begin
      ea = rt_v; eb = rs_v;
    end else begin
      ea = rs_v; eb = m.src ? immx : rt_v;
    end
    chk("m_valid", 32'(ex_valid), 32'(m.v));
    chk("m_alucon", 32'(ex_alucon), 32'(m.op));
    chk("m_a", ex_a, ea);
    chk("m_b", ex_b, eb);
    chk("m_store", ex_store_data, rt_v);
    chk("m_dest", 32'(ex_dest), 32'(m.dest));
    chk("m_ctrl", 32'(ex_ctrl), m.v ? 32'(m.ctrl) : 32'd0);
    chk("m_load_use", 32'(load_use), 32'(m_lu()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_alucon = 0; id_rs = 0; id_rt = 0; id_dest = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_alusrc = 0; id_signext = 0; id_uses_rt = 0; id_ctrl = 0;
    stall = 0; flush = 0;
    mem_regwrite = 0; mem_dest = 0; mem_result = 0;
    wb_regwrite = 0; wb_dest = 0; wb_result = 0;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [3:0] ctl);
    id_valid = 1; id_alucon = op; id_rs = rs; id_rt = rt;
    id_dest = rd; id_rs_data = rsd; id_rt_data = rtd;
    id_ctrl = ctl; id_uses_rt = 1; id_alusrc = 0;
    id_imm = 0; id_shamt = 0; id_signext = 0;
  endtask

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  initial begin
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_a", ex_a, 0);
    chk("rst_lu", 32'(load_use), 0);
    chk("rst_ctrl", 32'(ex_ctrl), 0);
    #10 rst_n = 1;
    step();

    // ADD r3 = r1 + r2
    set_id(ADD, 1, 2, 3, 5, 7, 4'b1000);
    step();
    chk("add_op", 32'(ex_alucon), 32'(ADD));
    chk("add_a", ex_a, 5);
    chk("add_b", ex_b, 7);
    chk("add_rw", 32'(ex_ctrl[3]), 1);

    // forwarding into SUB reading r1
    set_id(SUB, 1, 2, 6, 32'h99, 3, 4'b1000);
    step();
    mem_regwrite = 1; mem_dest = 1; mem_result = 32'h10;
    wb_regwrite = 1; wb_dest = 1; wb_result = 32'h20;
    #1 chk("fwd_mem", ex_a, 32'h10);
    mem_regwrite = 0;
    #1 chk("fwd_wb", ex_a, 32'h20);
    mem_regwrite = 1; mem_dest = 0; wb_dest = 0;
    #1 chk("fwd_r0", ex_a, 32'h99);
    mem_regwrite = 0; wb_regwrite = 0;

    // load-use on rt
    set_id(ADD, 5, 0, 4, 0, 0, 4'b1101);
    id_alusrc = 1; id_uses_rt = 0;
    step();
    set_id(ADD, 6, 4, 7, 1, 2, 4'b1000);
    #1 chk("lu_set", 32'(load_use), 1);
    step();
    chk("lu_bub_v", 32'(ex_valid), 0);
    chk("lu_bub_c", 32'(ex_ctrl), 0);
    step();
    chk("lu_in_v", 32'(ex_valid), 1);
    chk("lu_in_d", 32'(ex_dest), 7);

    // shifts
    set_id(6'b000000, 0, 2, 3, 0, 1, 4'b1000);
    id_shamt = 4;
    step();
    chk("sll_a", ex_a, 1);
    chk("sll_b", ex_b, 4);
    set_id(6'b000111, 3, 2, 3, 32'h23, 32'h8000_0000, 4'b1000);
    step();
    chk("srav_a", ex_a, 32'h8000_0000);
    chk("srav_b", ex_b, 32'h23);

    // immediate extension
    set_id(ADD, 1, 2, 2, 1, 32'h55, 4'b1000);
    id_alusrc = 1; id_imm = 16'hFFFF; id_signext = 1;
    step();
    chk("imm_sx", ex_b, 32'hFFFF_FFFF);
    chk("store", ex_store_data, 32'h55);
    id_signext = 0;
    step();
    chk("imm_zx", ex_b, 32'h0000_FFFF);

    // stall + flush together, then a held stall
    stall = 1; flush = 1;
    step();
    chk("sf_valid", 32'(ex_valid), 0);
    chk("sf_op", 32'(ex_alucon), 0);
    stall = 0; flush = 0;
    set_id(ADD, 1, 2, 9, 32'hAA, 32'hBB, 4'b1000);
    step();
    stall = 1;
    set_id(SUB, 3, 3, 3, 1, 1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_op", 32'(ex_alucon), 32'(ADD));
      chk("stl_a", ex_a, 32'hAA);
      chk("stl_d", 32'(ex_dest), 9);
    end
    #1 rst_n = 0;
    #1 chk("stl_rst", 32'(ex_valid), 0);
    rst_n = 1;
    stall = 0;

    // load_use masked by stall/flush
    set_id(ADD, 5, 0, 4, 0, 0, 4'b1101);
    step();
    set_id(ADD, 4, 0, 8, 0, 0, 4'b1000);
    stall = 1;
    #1 chk("lu_stall", 32'(load_use), 0);
    stall = 0; flush = 1;
    #1 chk("lu_flush", 32'(load_use), 0);
    flush = 0;
    #1 chk("lu_free", 32'(load_use), 1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step();
      id_valid   = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 7))
        0: id_alucon = 6'b000000;
        1: id_alucon = 6'b000011;
        2: id_alucon = 6'b000100;
        3: id_alucon = 6'b000111;
        4: id_alucon = SUB;
        default: id_alucon = ADD;
      endcase
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_dest    = 5'($urandom_range(0, 3));
      id_rs_data = $urandom;
      id_rt_data = $urandom;
      id_imm     = 16'($urandom);
      id_shamt   = 5'($urandom);
      id_alusrc  = 1'($urandom);
      id_signext = 1'($urandom);
      id_uses_rt = 1'($urandom);
      id_ctrl    = 4'($urandom);
      stall      = ($urandom_range(0, 9) == 0);
      flush      = ($urandom_range(0, 11) == 0);
      mem_regwrite = 1'($urandom);
      mem_dest   = 5'($urandom_range(0, 3));
      mem_result = $urandom;
      wb_regwrite = 1'($urandom);
      wb_dest    = 5'($urandom_range(0, 3));
      wb_result  = $urandom;
      if (i % 400 == 200) begin
        rst_n = 0;
        #1 rst_n = 1;
      end
    end
    step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports listed as name  direction  width  meaning.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID holds a real instruction.
REQ-005 id_alucon  in  6  ALU function code; encoding identical to the ALU's ALUCon.
REQ-006 id_rs, id_rt, id_dest  in  5 each  source/destination register numbers.
REQ-007 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-008 id_imm  in  16  immediate; id_shamt  in  5  shift amount.
REQ-009 id_alusrc, id_signext, id_uses_rt  in  1 each  B = immediate; sign-extend immediate; instruction reads rt.
REQ-010 id_ctrl  in  4  {regwrite, memread, memwrite, memtoreg}.
REQ-011 stall, flush  in  1 each  hold EX contents; kill the instruction entering EX.
REQ-012 mem_regwrite, mem_dest, mem_result  in  1/5/32  MEM-stage forwarding source.
REQ-013 wb_regwrite, wb_dest, wb_result  in  1/5/32  WB-stage forwarding source.
REQ-014 ex_valid  out  1; ex_alucon  out  6; ex_a, ex_b  out  32 each: ALU operands (A shifted by B for shifts).
REQ-015 ex_store_data  out  32; ex_dest  out  5; ex_ctrl  out  4; load_use  out  1: ID must hold this cycle.

Function
REQ-016 EX register fields (valid, alucon, rs, rt, dest, rs_data, rt_data, imm, shamt, alusrc, signext, ctrl) SHALL update on the rising clk edge; ex_a/ex_b/ex_store_data SHALL be combinational from these plus forwarding inputs.
REQ-017 Load priority per edge: flush > stall > load_use > normal load.
- flush: load bubble. stall: hold all fields. load_use: load bubble. normal: capture ID inputs.
REQ-018 Bubble SHALL be valid=0, alucon=6'b000000, dest=0, ctrl=0, all data fields 0.
REQ-019 load_use SHALL be combinational: ex_valid & ex_ctrl[memread] & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)) & id_valid.
REQ-020 load_use SHALL be 0 while stall or flush is 1.
REQ-021 Forwarded rs (frs): mem_result if mem_regwrite & mem_dest==ex_rs & ex_rs!=0; else wb_result if wb_regwrite & wb_dest==ex_rs & ex_rs!=0; else ex_rs_data. frt likewise with ex_rt. MEM SHALL win over WB.
REQ-022 Fixed shifts (alucon 000000, 000010, 000011): ex_a=frt, ex_b={27'b0,shamt}.
REQ-023 Variable shifts (000100, 000110, 000111): ex_a=frt, ex_b=frs (ALU uses B[4:0]).
REQ-024 All other codes: ex_a=frs; ex_b = alusrc ? imm-extended : frt.
- Extension: signext ? {16{imm[15]},imm} : {16'b0,imm}.
REQ-025 ex_store_data SHALL equal frt regardless of alucon.
REQ-026 When ex_valid=0, ex_ctrl SHALL read 0, so the bubble writes nothing and accesses no memory.
REQ-027 Latency: an instruction presented in ID with no stall, flush or load_use SHALL appear on the ex_* outputs exactly one cycle later.

Reset
REQ-028 While rst_n=0, all EX fields SHALL hold bubble values immediately, independent of clk; ex_a=ex_b=ex_store_data=0; load_use=0.
REQ-029 On the first rising edge after rst_n rises, normal priority (REQ-017) SHALL apply.
REQ-030 Reset asserted mid-stall or mid-load_use SHALL discard the held instruction.

Verification
REQ-031 ADD r3=r1+r2, rs_data=5, rt_data=7, no hazards -> next cycle ex_alucon=100000, ex_a=5, ex_b=7, ex_ctrl[regwrite]=1.
REQ-032 EX=ADD writing r1, ID=SUB reading r1; mem_result=0x10 for r1, wb_result=0x20 for r1 -> ex_a=0x10 (MEM priority); with mem_regwrite=0 -> ex_a=0x20; with dest r0 -> ex_a=rs_data.
REQ-033 EX=LW dest r4, ID reads r4 as rt with id_uses_rt=1 -> load_use=1; next cycle ex_valid=0, ex_ctrl=0; ID held, so the cycle after that the instruction enters EX.
REQ-034 SLL with shamt=4, rt_data=0x1 -> ex_a=0x1, ex_b=4; SRAV with rs_data=0x23, rt_data=0x80000000 -> ex_a=0x80000000, ex_b=0x23.
REQ-035 ADDI with imm=0xFFFF: signext=1 -> ex_b=0xFFFFFFFF; signext=0 -> ex_b=0x0000FFFF.
REQ-036 stall=1 and flush=1 on the same edge -> bubble loaded. stall=1 alone for 3 cycles -> EX fields unchanged. rst_n pulsed low mid-stall -> ex_valid=0 immediately.
